// File: rtl/reflet_addressable_io_arbiter_if.sv
// Request/ack bundle for the masters plus the bit-addressed IO bank pins.
// slave = arbiter side, master = environment (masters and bank) side.
interface reflet_addressable_io_arbiter_if #(
    parameter int nb_requesters = 2,
    parameter int addr_size     = 8
);
    logic [nb_requesters-1:0]           req;
    logic [nb_requesters-1:0]           req_write;
    logic [nb_requesters*addr_size-1:0] req_addr;
    logic [nb_requesters-1:0]           req_data;
    logic [nb_requesters-1:0]           ack;
    logic                               rd_gpi;
    logic                               rd_gpo;
    logic                               busy;
    logic [addr_size-1:0]               io_addr;
    logic                               io_gpo_write;
    logic                               io_edit_gpo;
    logic                               io_gpi_read;
    logic                               io_gpo_read;

    modport slave (
        input  req, req_write, req_addr, req_data, io_gpi_read, io_gpo_read,
        output ack, rd_gpi, rd_gpo, busy, io_addr, io_gpo_write, io_edit_gpo
    );

    modport master (
        output req, req_write, req_addr, req_data, io_gpi_read, io_gpo_read,
        input  ack, rd_gpi, rd_gpo, busy, io_addr, io_gpo_write, io_edit_gpo
    );
endinterface

// File: rtl/reflet_addressable_io_arbiter.sv
// Round-robin arbiter sharing one bit-addressed IO bank between nb_requesters masters.
// Ack 2 cycles after grant for reads / out-of-range, 3 for writes; masters hold req until ack.
module reflet_addressable_io_arbiter #(
    parameter int nb_requesters = 2,
    parameter int addr_size     = 8,
    parameter int number_of_io  = 128
) (
    input  logic clk,
    input  logic reset,
    reflet_addressable_io_arbiter_if.slave bus
);
    localparam int gw = (nb_requesters > 1) ? $clog2(nb_requesters) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, WRITE, ACK} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [gw-1:0]        last_grant;
    logic [gw-1:0]        grant;
    logic [gw-1:0]        pick;
    logic [gw-1:0]        cand;
    logic [addr_size-1:0] addr_q;
    logic [addr_size-1:0] sel_addr;
    logic                 write_q;
    logic                 data_q;
    logic                 rd_gpi_q;
    logic                 rd_gpo_q;
    logic                 any_req;
    logic                 in_range;

    assign any_req  = |bus.req;
    assign in_range = (32'(addr_q) < 32'(number_of_io));
    assign sel_addr = addr_size'(bus.req_addr >> (32'(pick) * 32'(addr_size)));

    // Scan from farthest to nearest so the index right after last_grant wins.
    always_comb begin
        pick = last_grant;
        cand = '0;
        for (int k = nb_requesters; k >= 1; k--) begin
            cand = gw'((32'(last_grant) + 32'(k)) % 32'(nb_requesters));
            if (bus.req[cand]) begin
                pick = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = SETUP;
            SETUP:   state_nxt = (write_q && in_range) ? WRITE : ACK;
            WRITE:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= gw'(nb_requesters - 1);
            grant      <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            data_q     <= 1'b0;
            rd_gpi_q   <= 1'b0;
            rd_gpo_q   <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                grant      <= pick;
                last_grant <= pick;
                addr_q     <= sel_addr;
                write_q    <= bus.req_write[pick];
                data_q     <= bus.req_data[pick];
            end
            // Out-of-range addresses read as zero instead of whatever the bank returns.
            if (state == SETUP) begin
                rd_gpi_q <= in_range & bus.io_gpi_read;
                rd_gpo_q <= in_range & bus.io_gpo_read;
            end
        end
    end

    for (genvar g = 0; g < nb_requesters; g++) begin : g_ack
        assign bus.ack[g] = (state == ACK) && (grant == gw'(g));
    end

    assign bus.rd_gpi       = rd_gpi_q;
    assign bus.rd_gpo       = rd_gpo_q;
    assign bus.busy         = (state != IDLE);
    assign bus.io_addr      = addr_q;
    assign bus.io_gpo_write = data_q;
    assign bus.io_edit_gpo  = (state == WRITE);
endmodule
